// File: rtl/grover_sequencer.sv
// Grover job sequencer: issues datapath commands one at a time, runs the
// configured number of oracle/diffuse iterations, and retries measurement on a table miss.
module grover_sequencer #(
  parameter  int NUM_QUBIT = 5,
  parameter  int BW_ITER   = 8,
  parameter  int MAX_TRIAL = 4,
  localparam int TW        = $clog2(MAX_TRIAL + 1)
) (
  input  logic                 clk,
  input  logic                 rstnn,
  input  logic                 start,
  input  logic                 abort,
  input  logic [BW_ITER-1:0]   cfg_iter,
  output logic                 cmd_valid,
  output logic [2:0]           cmd_op,
  input  logic                 cmd_ready,
  input  logic                 meas_valid,
  input  logic [NUM_QUBIT-1:0] meas_value,
  output logic [NUM_QUBIT-1:0] tbl_idx,
  input  logic                 tbl_hit,
  output logic                 busy,
  output logic                 done,
  output logic                 success,
  output logic                 no_solution,
  output logic [NUM_QUBIT-1:0] result,
  output logic [TW-1:0]        trial_cnt
);

  typedef enum logic [2:0] {
    S_IDLE, S_INIT, S_ORACLE, S_DMAC, S_DSUB, S_MEAS, S_WAIT, S_CHECK
  } state_e;

  localparam logic [2:0] OP_INIT = 3'd0, OP_ORACLE = 3'd1, OP_DMAC = 3'd2,
                         OP_DSUB = 3'd3, OP_MEAS   = 3'd4;

  state_e                 state_q;
  logic [BW_ITER-1:0]     iter_tgt_q, iter_cnt_q, iter_inc_d;
  logic                   done_q, success_q, no_sol_q;
  logic [NUM_QUBIT-1:0]   result_q;
  logic [TW-1:0]          trial_q;

  // Compare on the incremented count so a full-scale target never wraps.
  assign iter_inc_d = iter_cnt_q + BW_ITER'(1);

  always_comb begin
    cmd_valid = 1'b0;
    cmd_op    = OP_INIT;
    case (state_q)
      S_INIT:   begin cmd_valid = 1'b1; cmd_op = OP_INIT;   end
      S_ORACLE: begin cmd_valid = 1'b1; cmd_op = OP_ORACLE; end
      S_DMAC:   begin cmd_valid = 1'b1; cmd_op = OP_DMAC;   end
      S_DSUB:   begin cmd_valid = 1'b1; cmd_op = OP_DSUB;   end
      S_MEAS:   begin cmd_valid = 1'b1; cmd_op = OP_MEAS;   end
      default:  ;
    endcase
  end

  always_ff @(posedge clk or negedge rstnn) begin
    if (!rstnn) begin
      state_q    <= S_IDLE;
      iter_tgt_q <= '0;
      iter_cnt_q <= '0;
      done_q     <= 1'b0;
      success_q  <= 1'b0;
      no_sol_q   <= 1'b0;
      result_q   <= '0;
      trial_q    <= '0;
    end else begin
      done_q <= 1'b0;
      if (abort && state_q != S_IDLE) begin
        // Abort drops the job silently; result and trial count are left for inspection.
        state_q   <= S_IDLE;
        success_q <= 1'b0;
        no_sol_q  <= 1'b0;
      end else begin
        case (state_q)
          S_IDLE: if (start && !abort) begin
            state_q    <= S_INIT;
            iter_tgt_q <= (cfg_iter == '0) ? BW_ITER'(1) : cfg_iter;
            iter_cnt_q <= '0;
            trial_q    <= TW'(1);
            success_q  <= 1'b0;
            no_sol_q   <= 1'b0;
            result_q   <= '0;
          end
          S_INIT: if (cmd_ready) begin
            state_q    <= S_ORACLE;
            iter_cnt_q <= '0;
          end
          S_ORACLE: if (cmd_ready) state_q <= S_DMAC;
          S_DMAC:   if (cmd_ready) state_q <= S_DSUB;
          S_DSUB: if (cmd_ready) begin
            iter_cnt_q <= iter_inc_d;
            state_q    <= (iter_inc_d == iter_tgt_q) ? S_MEAS : S_ORACLE;
          end
          S_MEAS: if (cmd_ready) state_q <= S_WAIT;
          S_WAIT: if (meas_valid) begin
            result_q <= meas_value;
            state_q  <= S_CHECK;
          end
          S_CHECK: begin
            if (tbl_hit) begin
              success_q <= 1'b1;
              done_q    <= 1'b1;
              state_q   <= S_IDLE;
            end else if (trial_q == TW'(MAX_TRIAL)) begin
              no_sol_q <= 1'b1;
              done_q   <= 1'b1;
              state_q  <= S_IDLE;
            end else begin
              trial_q <= trial_q + TW'(1);
              state_q <= S_INIT;
            end
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign busy        = (state_q != S_IDLE);
  assign done        = done_q;
  assign success     = success_q;
  assign no_solution = no_sol_q;
  assign result      = result_q;
  assign tbl_idx     = result_q;
  assign trial_cnt   = trial_q;

endmodule

// File: tb/tb_grover_sequencer.sv
// Randomized bench for grover_sequencer: a job-level model predicts the accepted
// command stream, trial count and final flags from the function table and measurement plan.
module tb_grover_sequencer;
  localparam int NQ = 5, BW = 8, MT = 4, TW = $clog2(MT + 1);

  logic clk = 1'b0, rstnn = 1'b0, start = 1'b0, abort = 1'b0;
  logic cmd_ready = 1'b0, meas_valid = 1'b0;
  logic [BW-1:0] cfg_iter = '0;
  logic [NQ-1:0] meas_value = '0;
  logic cmd_valid, tbl_hit, busy, done, success, no_solution;
  logic [2:0] cmd_op;
  logic [NQ-1:0] tbl_idx, result;
  logic [TW-1:0] trial_cnt;
  logic [31:0] func_tbl = '0;

  assign tbl_hit = func_tbl[tbl_idx];

  grover_sequencer #(.NUM_QUBIT(NQ), .BW_ITER(BW), .MAX_TRIAL(MT)) dut (
    .clk(clk), .rstnn(rstnn), .start(start), .abort(abort), .cfg_iter(cfg_iter),
    .cmd_valid(cmd_valid), .cmd_op(cmd_op), .cmd_ready(cmd_ready),
    .meas_valid(meas_valid), .meas_value(meas_value), .tbl_idx(tbl_idx),
    .tbl_hit(tbl_hit), .busy(busy), .done(done), .success(success),
    .no_solution(no_solution), .result(result), .trial_cnt(trial_cnt)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_fail = 0;
  logic [NQ-1:0] plan [MT];
  logic [2:0] obs_ops[$], exp_ops[$];
  int busy_cycles, exp_trials, exp_tgt;
  bit done_seen, timed_out, exp_success;
  logic done_after;
  logic [NQ-1:0] exp_result;

  // Job-level reference: each trial is INIT, tgt x (ORACLE,DMAC,DSUB), MEASURE;
  // trials stop at the first planned measurement that hits the table.
  task automatic model_job(input int cfg);
    exp_tgt = (cfg == 0) ? 1 : cfg;
    exp_ops.delete();
    exp_success = 0;
    exp_trials = 0;
    exp_result = '0;
    for (int t = 0; t < MT; t++) begin
      exp_ops.push_back(3'd0);
      for (int i = 0; i < exp_tgt; i++) begin
        exp_ops.push_back(3'd1); exp_ops.push_back(3'd2); exp_ops.push_back(3'd3);
      end
      exp_ops.push_back(3'd4);
      exp_trials = t + 1;
      exp_result = plan[t];
      if (func_tbl[plan[t]]) begin exp_success = 1; break; end
    end
  endtask

  function automatic bit ops_match();
    if (obs_ops.size() != exp_ops.size()) return 0;
    foreach (obs_ops[i]) if (obs_ops[i] !== exp_ops[i]) return 0;
    return 1;
  endfunction

  function automatic int count_op(input logic [2:0] op, input bit stop_at_meas);
    int n = 0;
    foreach (obs_ops[i]) begin
      if (stop_at_meas && obs_ops[i] == 3'd4) break;
      if (obs_ops[i] == op) n++;
    end
    return n;
  endfunction

  // Drives one job to completion acting as the datapath; records accepted commands.
  task automatic run_job(input logic [BW-1:0] cfg, input int dmac_stall, input bit rnd);
    int stall_cnt = 0, mwait = -1, mi = 0, guard = 0;
    obs_ops.delete();
    busy_cycles = 0; done_seen = 0; timed_out = 0; done_after = 1'b0;
    @(negedge clk);
    cfg_iter = cfg; start = 1'b1; abort = 1'b0; cmd_ready = 1'b0; meas_valid = 1'b0;
    @(negedge clk);
    start = 1'b0;
    cfg_iter = BW'($urandom);
    while (!done_seen) begin
      if (guard++ > 5000) begin timed_out = 1; break; end
      if (done) begin done_seen = 1; break; end
      if (busy) busy_cycles++;
      if (cmd_valid && cmd_op == 3'd2 && stall_cnt < dmac_stall) begin
        cmd_ready = 1'b0; stall_cnt++;
      end else begin
        cmd_ready = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
      end
      meas_valid = 1'b0;
      start = 1'b0;
      if (mwait > 0) mwait--;
      else if (mwait == 0) begin
        meas_valid = 1'b1;
        meas_value = (mi < MT) ? plan[mi] : '0;
        mi++; mwait = -1;
      end else if (rnd && $urandom_range(0, 7) == 0) begin
        meas_valid = 1'b1; meas_value = NQ'($urandom);
      end
      if (rnd && busy && $urandom_range(0, 5) == 0) start = 1'b1;
      if (cmd_valid && cmd_ready) begin
        obs_ops.push_back(cmd_op);
        if (cmd_op == 3'd2) stall_cnt = 0;
        if (cmd_op == 3'd4) mwait = rnd ? $urandom_range(0, 2) : 0;
      end
      @(negedge clk);
    end
    start = 1'b0; meas_valid = 1'b0; cmd_ready = 1'b0;
    if (done_seen) begin @(negedge clk); done_after = done; end
  endtask

  task automatic test_reset;
    rstnn = 1'b0; #12;
    n_chk++; if ({cmd_valid, cmd_op} !== 4'b0) begin n_fail++; $display("FAIL reset_cmd: got %b want 0000", {cmd_valid, cmd_op}); end
    n_chk++; if ({busy, done, success, no_solution} !== 4'b0) begin n_fail++; $display("FAIL reset_flags: got %b want 0000", {busy, done, success, no_solution}); end
    n_chk++; if ({result, tbl_idx, trial_cnt} !== '0) begin n_fail++; $display("FAIL reset_data: result %0d tbl_idx %0d trial %0d want 0", result, tbl_idx, trial_cnt); end
    @(negedge clk); rstnn = 1'b1;
    @(negedge clk);
    n_chk++; if (busy !== 1'b0 || cmd_valid !== 1'b0) begin n_fail++; $display("FAIL reset_idle: busy %b cmd_valid %b want 0 0", busy, cmd_valid); end
  endtask

  task automatic test_basic_hit;
    func_tbl = 32'h1 << 5;
    plan[0] = 5; for (int i = 1; i < MT; i++) plan[i] = NQ'($urandom);
    model_job(2);
    run_job(8'd2, 0, 0);
    n_chk++; if (timed_out) begin n_fail++; $display("FAIL basic_timeout: no done within budget"); end
    n_chk++; if (!ops_match()) begin n_fail++; $display("FAIL basic_ops: got %0d cmds want %0d", obs_ops.size(), exp_ops.size()); end
    n_chk++; if (busy_cycles != 10) begin n_fail++; $display("FAIL basic_latency: got %0d busy cycles want 10", busy_cycles); end
    n_chk++; if ({success, no_solution} !== 2'b10) begin n_fail++; $display("FAIL basic_flags: got %b want 10", {success, no_solution}); end
    n_chk++; if (result !== 5 || tbl_idx !== 5) begin n_fail++; $display("FAIL basic_result: result %0d tbl_idx %0d want 5", result, tbl_idx); end
    n_chk++; if (trial_cnt !== 1) begin n_fail++; $display("FAIL basic_trial: got %0d want 1", trial_cnt); end
    n_chk++; if (done_after !== 1'b0) begin n_fail++; $display("FAIL basic_done_pulse: done still %b second cycle want 0", done_after); end
  endtask

  task automatic test_exhaust;
    func_tbl = '0;
    for (int i = 0; i < MT; i++) plan[i] = NQ'($urandom);
    model_job(1);
    run_job(8'd1, 0, 1);
    n_chk++; if (timed_out) begin n_fail++; $display("FAIL exhaust_timeout: no done within budget"); end
    n_chk++; if (!ops_match()) begin n_fail++; $display("FAIL exhaust_ops: got %0d cmds want %0d", obs_ops.size(), exp_ops.size()); end
    n_chk++; if (count_op(3'd0, 0) != MT) begin n_fail++; $display("FAIL exhaust_inits: got %0d want %0d", count_op(3'd0, 0), MT); end
    n_chk++; if ({success, no_solution} !== 2'b01) begin n_fail++; $display("FAIL exhaust_flags: got %b want 01", {success, no_solution}); end
    n_chk++; if (trial_cnt !== TW'(MT)) begin n_fail++; $display("FAIL exhaust_trial: got %0d want %0d", trial_cnt, MT); end
    n_chk++; if (result !== plan[MT-1]) begin n_fail++; $display("FAIL exhaust_result: got %0d want %0d", result, plan[MT-1]); end
  endtask

  task automatic test_backpressure;
    func_tbl = '1;
    for (int i = 0; i < MT; i++) plan[i] = NQ'($urandom);
    model_job(3);
    run_job(8'd3, 3, 0);
    n_chk++; if (timed_out) begin n_fail++; $display("FAIL bp_timeout: no done within budget"); end
    n_chk++; if (!ops_match()) begin n_fail++; $display("FAIL bp_ops: got %0d cmds want %0d", obs_ops.size(), exp_ops.size()); end
    n_chk++; if (busy_cycles != exp_trials * (4 + 3 * exp_tgt + 3 * exp_tgt)) begin n_fail++; $display("FAIL bp_latency: got %0d want %0d", busy_cycles, exp_trials * (4 + 6 * exp_tgt)); end
    n_chk++; if (success !== 1'b1 || result !== plan[0]) begin n_fail++; $display("FAIL bp_result: success %b result %0d want 1 %0d", success, result, plan[0]); end
  endtask

  task automatic test_iter_bounds;
    int cfgs[2] = '{0, 255};
    int want[2] = '{1, 255};
    func_tbl = '1;
    foreach (cfgs[k]) begin
      for (int i = 0; i < MT; i++) plan[i] = NQ'($urandom);
      model_job(cfgs[k]);
      run_job(BW'(cfgs[k]), 0, 0);
      n_chk++; if (timed_out) begin n_fail++; $display("FAIL iter%0d_timeout: no done within budget", cfgs[k]); end
      n_chk++; if (count_op(3'd1, 1) != want[k]) begin n_fail++; $display("FAIL iter%0d_oracles: got %0d want %0d", cfgs[k], count_op(3'd1, 1), want[k]); end
      n_chk++; if (!ops_match()) begin n_fail++; $display("FAIL iter%0d_ops: got %0d cmds want %0d", cfgs[k], obs_ops.size(), exp_ops.size()); end
      n_chk++; if (busy_cycles != 4 + 3 * want[k]) begin n_fail++; $display("FAIL iter%0d_latency: got %0d want %0d", cfgs[k], busy_cycles, 4 + 3 * want[k]); end
    end
  endtask

  task automatic test_abort;
    int g = 0;
    func_tbl = '1;
    @(negedge clk); cfg_iter = 8'd2; start = 1'b1;
    @(negedge clk); start = 1'b0; cmd_ready = 1'b1;
    while (!(cmd_valid && cmd_op == 3'd3) && g < 50) begin @(negedge clk); g++; end
    n_chk++; if (g >= 50) begin n_fail++; $display("FAIL abort_reach_dsub: DIFF_SUB never issued"); end
    abort = 1'b1; start = 1'b1;
    @(negedge clk);
    n_chk++; if ({busy, cmd_valid, done} !== 3'b0) begin n_fail++; $display("FAIL abort_idle: busy/valid/done %b want 000", {busy, cmd_valid, done}); end
    n_chk++; if ({success, no_solution} !== 2'b0) begin n_fail++; $display("FAIL abort_flags: got %b want 00", {success, no_solution}); end
    n_chk++; if (trial_cnt !== 1 || result !== 0) begin n_fail++; $display("FAIL abort_hold: trial %0d result %0d want 1 0", trial_cnt, result); end
    @(negedge clk); abort = 1'b0; start = 1'b0; cmd_ready = 1'b0;
    n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL abort_beats_start: busy %b want 0", busy); end
    @(negedge clk);
    n_chk++; if (done !== 1'b0) begin n_fail++; $display("FAIL abort_no_done: done %b want 0", done); end
    for (int i = 0; i < MT; i++) plan[i] = NQ'($urandom);
    model_job(4);
    run_job(8'd4, 0, 0);
    n_chk++; if (timed_out || !ops_match()) begin n_fail++; $display("FAIL abort_fresh_ops: timeout %b got %0d cmds want %0d", timed_out, obs_ops.size(), exp_ops.size()); end
    n_chk++; if (success !== 1'b1 || trial_cnt !== 1) begin n_fail++; $display("FAIL abort_fresh_flags: success %b trial %0d want 1 1", success, trial_cnt); end
  endtask

  task automatic test_reset_in_wait;
    int g = 0;
    func_tbl = '1;
    @(negedge clk); cfg_iter = 8'd1; start = 1'b1; cmd_ready = 1'b1;
    @(negedge clk); start = 1'b0;
    while (!(cmd_valid && cmd_op == 3'd4) && g < 50) begin @(negedge clk); g++; end
    n_chk++; if (g >= 50) begin n_fail++; $display("FAIL rstwait_reach_meas: MEASURE never issued"); end
    @(negedge clk); cmd_ready = 1'b0;
    n_chk++; if (busy !== 1'b1 || cmd_valid !== 1'b0) begin n_fail++; $display("FAIL rstwait_in_wait: busy %b valid %b want 1 0", busy, cmd_valid); end
    #2 rstnn = 1'b0; #1;
    n_chk++; if ({busy, cmd_valid, cmd_op, done, success, no_solution} !== '0) begin n_fail++; $display("FAIL rstwait_ctrl: got %b want 0", {busy, cmd_valid, cmd_op, done, success, no_solution}); end
    n_chk++; if ({result, tbl_idx, trial_cnt} !== '0) begin n_fail++; $display("FAIL rstwait_data: result %0d trial %0d want 0", result, trial_cnt); end
    @(negedge clk); rstnn = 1'b1;
    for (int i = 0; i < MT; i++) plan[i] = NQ'($urandom);
    func_tbl = 32'h1 << plan[1];
    if (plan[0] == plan[1]) plan[0] = plan[1] ^ 5'd1;
    model_job(2);
    run_job(8'd2, 0, 0);
    n_chk++; if (timed_out || !ops_match()) begin n_fail++; $display("FAIL rstwait_recover_ops: timeout %b got %0d cmds want %0d", timed_out, obs_ops.size(), exp_ops.size()); end
    n_chk++; if (trial_cnt !== 2 || success !== 1'b1) begin n_fail++; $display("FAIL rstwait_recover: trial %0d success %b want 2 1", trial_cnt, success); end
  endtask

  task automatic test_random;
    for (int j = 0; j < 12; j++) begin
      int cfg = $urandom_range(0, 6);
      int st = $urandom_range(0, 2);
      func_tbl = $urandom & $urandom;
      for (int i = 0; i < MT; i++) plan[i] = NQ'($urandom);
      model_job(cfg);
      run_job(BW'(cfg), st, 1);
      n_chk++; if (timed_out || !ops_match()) begin n_fail++; $display("FAIL rand%0d_ops: timeout %b got %0d cmds want %0d", j, timed_out, obs_ops.size(), exp_ops.size()); end
      n_chk++; if ({success, no_solution} !== {exp_success, !exp_success}) begin n_fail++; $display("FAIL rand%0d_flags: got %b want %b", j, {success, no_solution}, {exp_success, !exp_success}); end
      n_chk++; if (result !== exp_result || tbl_idx !== exp_result) begin n_fail++; $display("FAIL rand%0d_result: got %0d want %0d", j, result, exp_result); end
      n_chk++; if (trial_cnt !== TW'(exp_trials)) begin n_fail++; $display("FAIL rand%0d_trial: got %0d want %0d", j, trial_cnt, exp_trials); end
      n_chk++; if (done_after !== 1'b0) begin n_fail++; $display("FAIL rand%0d_done_pulse: done %b second cycle want 0", j, done_after); end
    end
  endtask

  initial begin
    test_reset();
    test_basic_hit();
    test_exhaust();
    test_backpressure();
    test_iter_bounds();
    test_abort();
    test_reset_in_wait();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
